// File: rtl/sdram_pattern_tester.sv
// rtl/sdram_pattern_tester.sv - SDRAM write/read-back pattern self-test engine on the SdramCtrl user port
// Optional LFSR pattern for mode 2 is built only when SDRAM_TEST_LFSR_EN is defined.
module sdram_pattern_tester #(
    parameter int                ADDR_W    = 24,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                LEN       = 256,
    parameter logic [15:0]       PATTERN   = 16'hF055,
    parameter logic [15:0]       SEED      = 16'hACE1,
    parameter int                INIT_WAIT = 25000,
    parameter int                TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              sdram_req,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rh_wl,
    output logic [DATA_W-1:0] sdram_data_w,
    input  logic              sdram_ack,
    input  logic [DATA_W-1:0] sdram_data_r,
    input  logic              sdram_data_r_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [7:0]        led
);

    localparam int IDX_W  = ($clog2(LEN) > 7) ? $clog2(LEN) : 7;
    localparam int INIT_W = ($clog2(INIT_WAIT + 1) > 1) ? $clog2(INIT_WAIT + 1) : 1;
    localparam int TMO_W  = ($clog2(TIMEOUT) > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DATA_W-1:0] PAT_D = DATA_W'(PATTERN);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [INIT_W-1:0]   init_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [IDX_W-1:0]    idx;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   rd_q, rd_cmp, pat_cur;
    logic                req_st, wait_st, start_ok, wr_ack, rd_ack, last_idx, tmo_hit, miss;

`ifdef SDRAM_TEST_LFSR_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_step;

    assign lfsr_step = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // Reseeded at the write->read turn so reads regenerate the written sequence
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (start_ok) begin
            lfsr <= SEED;
        end else if (wr_ack) begin
            lfsr <= last_idx ? SEED : lfsr_step;
        end else if (rd_ack) begin
            lfsr <= lfsr_step;
        end
    end
`endif

    always_comb begin
        pat_cur = PAT_D;
        case (mode_q)
            2'd1: pat_cur = DATA_W'(sdram_addr);
`ifdef SDRAM_TEST_LFSR_EN
            2'd2: for (int k = 0; k < DATA_W; k++) pat_cur[k] = lfsr[k % 16];
`else
            2'd2: pat_cur = DATA_W'(sdram_addr);
`endif
            2'd3: pat_cur = idx[0] ? ~PAT_D : PAT_D;
            default: pat_cur = PAT_D;
        endcase
    end

    always_comb begin
        req_st    = (state == S_WR_REQ) || (state == S_RD_REQ);
        wait_st   = (state == S_WR_WAIT) || (state == S_RD_WAIT);
        start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
        wr_ack    = (state == S_WR_WAIT) && sdram_ack;
        rd_ack    = (state == S_RD_WAIT) && sdram_ack;
        last_idx  = (idx == IDX_W'(LEN - 1));
        tmo_hit   = wait_st && !sdram_ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));
        rd_cmp    = sdram_data_r_en ? sdram_data_r : rd_q;
        miss      = (rd_cmp != pat_cur);
        state_nxt = state;
        case (state)
            S_INIT:    if (init_cnt == INIT_W'(INIT_WAIT - 1)) state_nxt = S_IDLE;
            S_IDLE:    if (start) state_nxt = S_WR_REQ;
            S_DONE:    if (start) state_nxt = S_WR_REQ;
            S_WR_REQ:  state_nxt = S_WR_WAIT;
            S_WR_WAIT: begin
                if (sdram_ack)    state_nxt = last_idx ? S_RD_REQ : S_WR_REQ;
                else if (tmo_hit) state_nxt = S_DONE;
            end
            S_RD_REQ:  state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (sdram_ack)    state_nxt = last_idx ? S_DONE : S_RD_REQ;
                else if (tmo_hit) state_nxt = S_DONE;
            end
            default:   state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt       <= '0;
            tmo_cnt        <= '0;
            idx            <= '0;
            mode_q         <= '0;
            rd_q           <= '0;
            sdram_addr     <= '0;
            sdram_rh_wl    <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
            if (sdram_data_r_en) rd_q <= sdram_data_r;
            // Counting from 1 in the first WAIT cycle makes expiry land TIMEOUT cycles after the REQ
            if (req_st)       tmo_cnt <= TMO_W'(1);
            else if (wait_st) tmo_cnt <= tmo_cnt + 1'b1;

            if (start_ok) begin
                mode_q         <= mode;
                idx            <= '0;
                sdram_addr     <= BASE_ADDR;
                sdram_rh_wl    <= 1'b0;
                done           <= 1'b0;
                pass           <= 1'b0;
                timeout        <= 1'b0;
                err_cnt        <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
            end else if (wr_ack) begin
                if (last_idx) begin
                    idx         <= '0;
                    sdram_addr  <= BASE_ADDR;
                    sdram_rh_wl <= 1'b1;
                end else begin
                    idx        <= idx + 1'b1;
                    sdram_addr <= sdram_addr + 1'b1;
                end
            end else if (rd_ack) begin
                if (miss) begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
                    if (err_cnt == 16'h0000) begin
                        first_err_addr <= sdram_addr;
                        first_err_data <= rd_cmp;
                    end
                end
                if (last_idx) begin
                    done <= 1'b1;
                    pass <= !miss && (err_cnt == 16'h0000);
                end else begin
                    idx        <= idx + 1'b1;
                    sdram_addr <= sdram_addr + 1'b1;
                end
            end else if (tmo_hit) begin
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

    assign sdram_req    = req_st;
    assign busy         = req_st || wait_st;
    assign sdram_data_w = sdram_rh_wl ? '0 : pat_cur;

    always_comb begin
        led = 8'h00;
        if (busy)                 led = {1'b1, idx[6:0]};
        else if (state == S_DONE) led = timeout ? 8'hF0 : (pass ? 8'h55 : 8'hAA);
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb/tb_sdram_pattern_tester.sv - self-checking bench with a behavioural SDRAM controller and pattern model
module tb_sdram_pattern_tester;

    localparam int          LEN       = 8;
    localparam int          INIT_WAIT = 40;
    localparam int          TIMEOUT   = 64;
    localparam logic [23:0] BASE      = 24'hFFFFFE;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        sdram_req, sdram_rh_wl, sdram_ack = 1'b0, sdram_data_r_en = 1'b0;
    logic [23:0] sdram_addr, first_err_addr;
    logic [15:0] sdram_data_w, sdram_data_r = 16'h0, first_err_data, err_cnt;
    logic        busy, done, pass, timeout;
    logic [7:0]  led;

    sdram_pattern_tester #(
        .ADDR_W(24), .DATA_W(16), .BASE_ADDR(BASE), .LEN(LEN),
        .INIT_WAIT(INIT_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_rh_wl(sdram_rh_wl),
        .sdram_data_w(sdram_data_w), .sdram_ack(sdram_ack), .sdram_data_r(sdram_data_r),
        .sdram_data_r_en(sdram_data_r_en), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .led(led)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [23:0] addr; logic rw; logic [15:0] data; int idx; } req_t;
    req_t        exp_q[$];
    req_t        cur, ce;
    logic [15:0] mem  [logic [23:0]];
    logic [15:0] flip [logic [23:0]];
    int pend = 0, lat_min = 3, lat_max = 3, req_seen = 0, exp_next_req = -1;
    int wr_req_n = 0, wr_ack_n = 0, hang_req_cyc = -1, last_ack_cyc = -1;
    bit drop_3rd_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_at(input int i);
        logic [15:0] s;
        s = 16'hACE1;
        for (int k = 0; k < i; k++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return s;
    endfunction

    function automatic logic [15:0] pat(input logic [1:0] m, input int i);
        logic [23:0] a;
        a = BASE + 24'(i);
        case (m)
            2'd0: return 16'hF055;
            2'd1: return a[15:0];
`ifdef SDRAM_TEST_LFSR_EN
            2'd2: return lfsr_at(i);
`else
            2'd2: return a[15:0];
`endif
            default: return (i % 2 == 1) ? 16'h0FAA : 16'hF055;
        endcase
    endfunction

    // Controller model (fixed/random ack latency, data_r_en with ack) and per-request compare
    always @(negedge clk) begin
        sdram_ack       = 1'b0;
        sdram_data_r_en = 1'b0;
        if (reset) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (!cur.rw) begin
                        wr_ack_n++;
                        if (!(drop_3rd_wr && wr_ack_n == 3)) begin
                            mem[cur.addr] = cur.data;
                            sdram_ack = 1'b1;
                        end
                    end else begin
                        sdram_ack       = 1'b1;
                        sdram_data_r_en = 1'b1;
                        sdram_data_r    = (mem.exists(cur.addr) ? mem[cur.addr] : 16'hDEAD) ^
                                          (flip.exists(cur.addr) ? flip[cur.addr] : 16'h0000);
                    end
                    if (sdram_ack) begin
                        exp_next_req = cyc + 1;
                        last_ack_cyc = cyc;
                    end
                end
            end
            if (sdram_req) begin
                req_seen++;
                if (!sdram_rh_wl) begin
                    wr_req_n++;
                    if (wr_req_n == 3) hang_req_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    chk("extra_req", 32'd1, 32'd0);
                end else begin
                    ce = exp_q.pop_front();
                    chk("req_addr", sdram_addr, ce.addr);
                    chk("req_rw", sdram_rh_wl, ce.rw);
                    if (!ce.rw) chk("req_wdata", sdram_data_w, ce.data);
                    chk("req_led", led, {1'b1, 7'(ce.idx)});
                    chk("req_busy", busy, 1);
                    if (exp_next_req >= 0) chk("req_timing", cyc, exp_next_req);
                end
                cur.addr = sdram_addr;
                cur.rw   = sdram_rh_wl;
                cur.data = sdram_data_w;
                pend     = $urandom_range(lat_max, lat_min);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, sdram_req, 0);       chk({tag, "_rhwl"}, sdram_rh_wl, 1);
        chk({tag, "_addr"}, sdram_addr, 0);     chk({tag, "_wdata"}, sdram_data_w, 0);
        chk({tag, "_busy"}, busy, 0);           chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);           chk({tag, "_tmo"}, timeout, 0);
        chk({tag, "_errcnt"}, err_cnt, 0);      chk({tag, "_faddr"}, first_err_addr, 0);
        chk({tag, "_fdata"}, first_err_data, 0); chk({tag, "_led"}, led, 0);
    endtask

    task automatic start_run(input logic [1:0] m);
        exp_q.delete();
        mem.delete();
        wr_req_n = 0;
        wr_ack_n = 0;
        for (int i = 0; i < LEN; i++) exp_q.push_back('{BASE + 24'(i), 1'b0, pat(m, i), i});
        for (int i = 0; i < LEN; i++) exp_q.push_back('{BASE + 24'(i), 1'b1, 16'h0, i});
        mode = m;
        start = 1'b1;
        exp_next_req = cyc + 1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_req", sdram_req, 1);
    endtask

    task automatic wait_done(output int dcyc);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            step();
            n++;
        end
        chk("done_seen", done, 1);
        dcyc = cyc;
    endtask

    task automatic expect_end(input string tag, input int e_err, input logic [23:0] fa,
                              input logic [15:0] fd, input logic [7:0] e_led, input bit e_to);
        chk({tag, "_pass"}, pass, (e_err == 0 && !e_to) ? 1 : 0);
        chk({tag, "_errcnt"}, err_cnt, e_err);
        chk({tag, "_faddr"}, first_err_addr, fa);
        chk({tag, "_fdata"}, first_err_data, fd);
        chk({tag, "_led"}, led, e_led);
        chk({tag, "_tmo"}, timeout, e_to);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic full_run(input string tag, input logic [1:0] m, input int e_err,
                            input logic [23:0] fa, input logic [15:0] fd);
        int dcyc;
        start_run(m);
        wait_done(dcyc);
        chk({tag, "_done_timing"}, dcyc, last_ack_cyc + 1);
        chk({tag, "_all_reqs"}, exp_q.size(), 0);
        expect_end(tag, e_err, fa, fd, (e_err == 0) ? 8'h55 : 8'hAA, 1'b0);
    endtask

    initial begin
        int n, dcyc, seen0, nf, exp_err, first, ii;
        logic [1:0]  m;
        logic [23:0] a;

        // Pin the model with hand-computed values
        chk("pin_wrap_addr_mode1", pat(2'd1, 2), 16'h0000);
        chk("pin_mode3_odd", pat(2'd3, 1), 16'h0FAA);
`ifdef SDRAM_TEST_LFSR_EN
        chk("pin_lfsr0", pat(2'd2, 0), 16'hACE1);
        chk("pin_lfsr1", pat(2'd2, 1), 16'h5670);
`else
        chk("pin_mode2_as_mode1", pat(2'd2, 1), 16'hFFFF);
`endif

        #1 reset = 1'b1;
        #1 check_reset_vals("rst_async");
        repeat (3) step();
        reset = 1'b0;

        repeat (10) step();
        seen0 = req_seen;
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        chk("init_start_ignored_busy", busy, 0);
        chk("init_start_ignored_req", req_seen, seen0);
        repeat (INIT_WAIT) step();

        full_run("const", 2'd0, 0, 24'h0, 16'h0);

        flip[24'h000005] = 16'h0001;
        full_run("bitflip", 2'd1, 1, 24'h000005, 16'h0004);
        flip.delete();

        full_run("mode2", 2'd2, 0, 24'h0, 16'h0);
        full_run("alt", 2'd3, 0, 24'h0, 16'h0);

        lat_min = 1;
        lat_max = 6;
        for (int r = 0; r < 6; r++) begin
            m = 2'($urandom_range(3, 0));
            nf = $urandom_range(3, 0);
            exp_err = 0;
            first = -1;
            flip.delete();
            for (int f = 0; f < nf; f++) begin
                ii = $urandom_range(LEN - 1, 0);
                a = BASE + 24'(ii);
                if (!flip.exists(a)) begin
                    flip[a] = 16'h0001 << $urandom_range(15, 0);
                    exp_err++;
                    if (first < 0 || ii < first) first = ii;
                end
            end
            start_run(m);
            repeat (4) step();
            mode = ~m; start = 1'b1; step(); start = 1'b0;
            wait_done(dcyc);
            chk("rand_done_timing", dcyc, last_ack_cyc + 1);
            chk("rand_all_reqs", exp_q.size(), 0);
            if (first < 0)
                expect_end("rand", 0, 24'h0, 16'h0, 8'h55, 1'b0);
            else
                expect_end("rand", exp_err, BASE + 24'(first),
                           pat(m, first) ^ flip[BASE + 24'(first)], 8'hAA, 1'b0);
        end
        flip.delete();
        lat_min = 3;
        lat_max = 3;

        drop_3rd_wr = 1'b1;
        start_run(2'd3);
        wait_done(dcyc);
        chk("hang_timing", dcyc, hang_req_cyc + TIMEOUT);
        expect_end("hang", 0, 24'h0, 16'h0, 8'hF0, 1'b1);
        seen0 = req_seen;
        repeat (100) step();
        chk("hang_no_more_req", req_seen, seen0);
        chk("hang_req_count", exp_q.size(), 2 * LEN - 3);
        drop_3rd_wr = 1'b0;

        start_run(2'd1);
        n = 0;
        while (!(busy && sdram_rh_wl && !sdram_req && exp_q.size() < LEN - 1) && n < 500) begin
            step();
            n++;
        end
        chk("reached_rd_wait", busy && sdram_rh_wl, 1);
        #1 reset = 1'b1;
        #1 check_reset_vals("rst_mid");
        repeat (2) step();
        chk("rst_hold_req", sdram_req, 0);
        reset = 1'b0;
        exp_q.delete();
        exp_next_req = -1;
        repeat (10) step();
        seen0 = req_seen;
        start = 1'b1; step(); start = 1'b0;
        repeat (3) step();
        chk("reinit_start_ignored", busy, 0);
        chk("reinit_no_req", req_seen, seen0);
        repeat (INIT_WAIT) step();
        full_run("after_rst", 2'd0, 0, 24'h0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
